// File: rtl/ram_rr_arbiter_if.sv
// Bundle of the requester, RAM-port and read-response signals shared by
// ram_rr_arbiter and whatever drives it. The slave modport is the arbiter's
// view; the master modport is the view of the requesters plus the RAM.
//
// Handshake: requester i transfers in a cycle where req_valid[i] and
// req_ready[i] are both high. Once req_valid[i] is raised, req_we[i],
// req_addr and req_wdata for that requester stay stable until the transfer.
// req_ready is combinational and never asserted without req_valid.
// rsp_valid is a one-cycle pulse with no back-pressure.
interface ram_rr_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
);
  logic                        arb_en;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_we;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]            req_ready;

  logic                        ram_cs;
  logic                        ram_we;
  logic                        ram_oe;
  logic [ADDR_WIDTH-1:0]       ram_addr;
  logic [DATA_WIDTH-1:0]       ram_wdata;
  logic [DATA_WIDTH-1:0]       ram_rdata;

  logic                        rsp_valid;
  logic [ID_WIDTH-1:0]         rsp_id;
  logic [DATA_WIDTH-1:0]       rsp_rdata;

  // Round-robin pointer, exported for observation only.
  logic [ID_WIDTH-1:0]         dbg_ptr;

  modport slave (
    input  arb_en, req_valid, req_we, req_addr, req_wdata, ram_rdata,
    output req_ready, ram_cs, ram_we, ram_oe, ram_addr, ram_wdata,
    output rsp_valid, rsp_id, rsp_rdata, dbg_ptr
  );

  modport master (
    output arb_en, req_valid, req_we, req_addr, req_wdata, ram_rdata,
    input  req_ready, ram_cs, ram_we, ram_oe, ram_addr, ram_wdata,
    input  rsp_valid, rsp_id, rsp_rdata, dbg_ptr
  );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM among N_REQ
// requesters. Grant is combinational; the winning request is registered
// onto the RAM port in the following cycle, and a read's data comes back
// as a tagged one-cycle response one cycle after that.
module ram_rr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  ram_rr_arbiter_if.slave  bus
);

  // One extra bit so ptr + offset can be compared against N_REQ.
  localparam int SW = ID_WIDTH + 1;

  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   grant_id;
  logic                  grant_vld;
  logic                  xfer;
  logic [SW-1:0]         scan_sum;
  logic [SW-1:0]         next_sum;
  logic [ID_WIDTH-1:0]   ptr_nxt;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [ID_WIDTH-1:0]   cmd_id;

  // Scan requesters starting at ptr, wrapping modulo N_REQ; first valid wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_sum  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = SW'(ptr) + SW'(k);
      if (scan_sum >= SW'(N_REQ)) begin
        scan_sum = scan_sum - SW'(N_REQ);
      end
      if (!grant_vld && bus.req_valid[scan_sum[ID_WIDTH-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = scan_sum[ID_WIDTH-1:0];
      end
    end
  end

  // A transfer needs both a winner and the global enable.
  assign xfer = grant_vld & bus.arb_en;

  // One-hot ready towards the winner only.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (xfer && (grant_id == ID_WIDTH'(i))) begin
        bus.req_ready[i] = 1'b1;
      end
    end
  end

  // Pick the winner's command fields out of the packed request buses.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pointer moves to the requester just after the winner, wrapping at N_REQ.
  always_comb begin
    next_sum = SW'(grant_id) + SW'(1);
    if (next_sum >= SW'(N_REQ)) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = next_sum[ID_WIDTH-1:0];
    end
  end

  // Round-robin pointer; holds when nothing transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= ptr_nxt;
    end
  end

  // Command stage: register the granted request onto the RAM port.
  // Address and write data hold across idle cycles; strobes drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ram_cs    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_oe    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      cmd_id        <= '0;
    end else begin
      bus.ram_cs <= xfer;
      bus.ram_we <= xfer & sel_we;
      bus.ram_oe <= xfer & ~sel_we;
      if (xfer) begin
        bus.ram_addr  <= sel_addr;
        bus.ram_wdata <= sel_wdata;
        cmd_id        <= grant_id;
      end
    end
  end

  // Pending-read stage: a read command this cycle becomes a tagged response
  // next cycle, when the RAM presents its data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
    end else begin
      bus.rsp_valid <= bus.ram_cs & bus.ram_oe;
      if (bus.ram_cs && bus.ram_oe) begin
        bus.rsp_id <= cmd_id;
      end
    end
  end

  // Read data is passed straight through and zeroed outside a response.
  assign bus.rsp_rdata = bus.rsp_valid ? bus.ram_rdata : '0;
  assign bus.dbg_ptr   = ptr;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter with a small synchronous RAM model.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_ram_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int IW = 2;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  ram_rr_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  ram_rr_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: write commits on the edge ending the command cycle,
  // read data appears in the cycle after the read command.
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_cs && bus.ram_oe) bus.ram_rdata <= mem[bus.ram_addr];
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]           = v;
    bus.req_we[i]              = we;
    bus.req_addr[i*AW +: AW]   = a;
    bus.req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [3:0] e_rdy;

  initial begin
    for (int a = 0; a < (1<<AW); a++) mem[a] = 32'hA000_0000 | a;
    bus.ram_rdata = '0;
    bus.arb_en    = 1'b0;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst = 1'b1;

    // reset state
    cyc(); cyc(); #1;
    chk("rst_ptr", bus.dbg_ptr, 0);
    chk("rst_cs", bus.ram_cs, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_wdata", bus.ram_wdata, 0);
    chk("rst_rsp", bus.rsp_valid, 0);
    chk("rst_rspid", bus.rsp_id, 0);

    // all four read continuously: grants 0,1,2,3,0,... responses two behind
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k == 0) begin
        rst = 1'b0;
        bus.arb_en = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(10 + i), '0);
      end
      #1;
      e_rdy = 4'b0001 << (k % 4);
      chk("rr_ready", bus.req_ready, e_rdy);
      if (k >= 1) begin
        chk("rr_cs", bus.ram_cs, 1);
        chk("rr_oe", bus.ram_oe, 1);
        chk("rr_addr", bus.ram_addr, 10 + ((k - 1) % 4));
      end else begin
        chk("rr_cs0", bus.ram_cs, 0);
      end
      if (k >= 2) begin
        chk("rr_rsp", bus.rsp_valid, 1);
        chk("rr_rspid", bus.rsp_id, (k - 2) % 4);
        chk("rr_rdata", bus.rsp_rdata, 32'hA000_0000 | (10 + ((k - 2) % 4)));
      end else begin
        chk("rr_rsp0", bus.rsp_valid, 0);
      end
    end
    cyc(); bus.req_valid = '0; #1;
    chk("drain_ready", bus.req_ready, 0);
    chk("drain_addr", bus.ram_addr, 13);
    chk("drain_rspid", bus.rsp_id, 2);
    cyc(); #1;
    chk("idle_cs", bus.ram_cs, 0);
    chk("idle_oe", bus.ram_oe, 0);
    chk("hold_addr", bus.ram_addr, 13);
    chk("drain_rspid3", bus.rsp_id, 3);
    chk("drain_rdata3", bus.rsp_rdata, 32'hA000_000D);
    cyc(); #1;
    chk("idle_rsp", bus.rsp_valid, 0);
    chk("idle_ptr", bus.dbg_ptr, 0);

    // write 0xDEADBEEF by req 2, then read-after-write by req 1
    cyc(); set_req(2, 1'b1, 1'b1, 6'd5, 32'hDEAD_BEEF); #1;
    chk("raw_wr_ready", bus.req_ready, 4'b0100);
    cyc(); set_req(2, 1'b0, 1'b0, 6'd0, '0); set_req(1, 1'b1, 1'b0, 6'd5, '0); #1;
    chk("raw_rd_ready", bus.req_ready, 4'b0010);
    chk("raw_wr_cs", bus.ram_cs, 1);
    chk("raw_wr_we", bus.ram_we, 1);
    chk("raw_wr_oe", bus.ram_oe, 0);
    chk("raw_wr_addr", bus.ram_addr, 5);
    chk("raw_wr_data", bus.ram_wdata, 32'hDEAD_BEEF);
    cyc(); set_req(1, 1'b0, 1'b0, 6'd0, '0); #1;
    chk("raw_rd_oe", bus.ram_oe, 1);
    chk("raw_rd_we", bus.ram_we, 0);
    chk("raw_no_wr_rsp", bus.rsp_valid, 0);
    chk("raw_ptr", bus.dbg_ptr, 2);
    cyc(); #1;
    chk("raw_rsp", bus.rsp_valid, 1);
    chk("raw_rspid", bus.rsp_id, 1);
    chk("raw_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);

    // req 0 and 2 valid with ptr=1: 2 first, then 0
    cyc(); set_req(0, 1'b1, 1'b0, 6'd20, '0); #1;
    chk("p1_setup_ready", bus.req_ready, 4'b0001);
    cyc(); set_req(2, 1'b1, 1'b0, 6'd22, '0); #1;
    chk("p1_ptr", bus.dbg_ptr, 1);
    chk("p1_first", bus.req_ready, 4'b0100);
    cyc(); set_req(2, 1'b0, 1'b0, 6'd0, '0); #1;
    chk("p1_second", bus.req_ready, 4'b0001);
    chk("p1_ptr3", bus.dbg_ptr, 3);
    chk("p1_rspid", bus.rsp_id, 0);
    chk("p1_rdata", bus.rsp_rdata, 32'hA000_0014);

    // only req 3 valid
    cyc(); set_req(0, 1'b0, 1'b0, 6'd0, '0); set_req(3, 1'b1, 1'b0, 6'd30, '0); #1;
    chk("r3_ready_p1", bus.req_ready, 4'b1000);
    chk("r3_rspid2", bus.rsp_id, 2);
    cyc(); #1;
    chk("r3_ptr0", bus.dbg_ptr, 0);
    chk("r3_ready_p0", bus.req_ready, 4'b1000);
    cyc(); set_req(3, 1'b0, 1'b0, 6'd0, '0); #1;
    chk("r3_ptr_wrap", bus.dbg_ptr, 0);
    chk("r3_none", bus.req_ready, 0);

    // arb_en low blocks new grants; in-flight read still completes
    cyc(); set_req(1, 1'b1, 1'b0, 6'd40, '0); #1;
    chk("en_last_grant", bus.req_ready, 4'b0010);
    cyc();
    bus.arb_en = 1'b0;
    set_req(0, 1'b1, 1'b0, 6'd50, '0);
    set_req(2, 1'b1, 1'b0, 6'd52, '0);
    set_req(3, 1'b1, 1'b0, 6'd53, '0);
    #1;
    chk("en_off_ready", bus.req_ready, 0);
    chk("en_inflight_cs", bus.ram_cs, 1);
    chk("en_inflight_addr", bus.ram_addr, 40);
    cyc(); #1;
    chk("en_off_ready2", bus.req_ready, 0);
    chk("en_off_cs", bus.ram_cs, 0);
    chk("en_rsp", bus.rsp_valid, 1);
    chk("en_rspid", bus.rsp_id, 1);
    chk("en_rdata", bus.rsp_rdata, 32'hA000_0028);
    cyc(); #1;
    chk("en_off_cs2", bus.ram_cs, 0);
    chk("en_off_rsp", bus.rsp_valid, 0);
    chk("en_off_ptr", bus.dbg_ptr, 2);
    cyc(); bus.arb_en = 1'b1; #1;
    chk("en_on_ready", bus.req_ready, 4'b0100);
    cyc(); bus.req_valid = '0; #1;
    chk("en_on_ptr", bus.dbg_ptr, 3);

    // reset in the cycle after a read grant discards it
    cyc(); set_req(0, 1'b1, 1'b0, 6'd50, '0); #1;
    chk("rr_rst_grant", bus.req_ready, 4'b0001);
    cyc(); set_req(0, 1'b0, 1'b0, 6'd0, '0); #1;
    chk("rr_rst_cs_pre", bus.ram_cs, 1);
    #2 rst = 1'b1; #1;
    chk("rr_rst_cs", bus.ram_cs, 0);
    chk("rr_rst_oe", bus.ram_oe, 0);
    chk("rr_rst_rsp", bus.rsp_valid, 0);
    chk("rr_rst_ptr", bus.dbg_ptr, 0);
    cyc();
    rst = 1'b0;
    set_req(1, 1'b1, 1'b0, 6'd33, '0);
    set_req(3, 1'b1, 1'b0, 6'd35, '0);
    #1;
    chk("post_rst_rsp", bus.rsp_valid, 0);
    chk("post_rst_ready", bus.req_ready, 4'b0010);
    cyc(); set_req(1, 1'b0, 1'b0, 6'd0, '0); #1;
    chk("post_rst_rsp2", bus.rsp_valid, 0);
    chk("post_rst_ready2", bus.req_ready, 4'b1000);
    chk("post_rst_addr", bus.ram_addr, 33);
    cyc(); bus.req_valid = '0; #1;
    chk("post_rst_rspv", bus.rsp_valid, 1);
    chk("post_rst_rspid", bus.rsp_id, 1);
    chk("post_rst_rdata", bus.rsp_rdata, 32'hA000_0021);
    cyc(); #1;
    chk("post_rst_rspid3", bus.rsp_id, 3);
    chk("post_rst_rdata3", bus.rsp_rdata, 32'hA000_0023);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_rr_arbiter.md
RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one RAM port (2..8).
REQ-002 Parameter ADDR_WIDTH, default 6, RAM address width.
REQ-003 Parameter DATA_WIDTH, default 32, RAM data width.
REQ-004 Parameter ID_WIDTH, default 2, requester-index width (clog2(N_REQ), min 1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 arb_en  input  1  grant enable; low = no new grants.
REQ-008 req_valid  input  N_REQ  per-requester request pending.
REQ-009 req_we  input  N_REQ  per-requester 1 = write, 0 = read.
REQ-010 req_addr  input  N_REQ*ADDR_WIDTH  packed addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 req_wdata  input  N_REQ*DATA_WIDTH  packed write data, same packing.
REQ-012 req_ready  output  N_REQ  one-hot grant, combinational, same cycle as accepted request.
REQ-013 ram_cs, ram_we, ram_oe  output  1 each  registered RAM port controls.
REQ-014 ram_addr  output  ADDR_WIDTH  registered RAM address.
REQ-015 ram_wdata  output  DATA_WIDTH  registered RAM write data.
REQ-016 ram_rdata  input  DATA_WIDTH  RAM read data, valid one cycle after a registered read command.
REQ-017 rsp_valid  output  1  read response valid, one-cycle pulse.
REQ-018 rsp_id  output  ID_WIDTH  requester index owning the response.
REQ-019 rsp_rdata  output  DATA_WIDTH  read data, equals ram_rdata while rsp_valid=1.

Function
REQ-020 Handshake: a transfer of requester i occurs in cycle t when req_valid[i]=1 and req_ready[i]=1; requesters hold valid/we/addr/wdata stable until then.
REQ-021 At most one req_ready bit is high per cycle; req_ready is all-zero when arb_en=0 or no req_valid bit is set.
REQ-022 Round-robin: 3-bit-max pointer ptr (ID_WIDTH bits) names the highest-priority requester; the winner is the first i with req_valid[i]=1 scanning ptr, ptr+1, ... modulo N_REQ.
REQ-023 After a transfer by requester g, ptr <= (g+1) mod N_REQ; with no transfer, ptr holds.
REQ-024 Command stage: on a transfer at cycle t, in cycle t+1 ram_cs=1, ram_we=req_we[g], ram_oe=~req_we[g], ram_addr/ram_wdata = granted requester's values.
REQ-025 Without a transfer at t, cycle t+1 has ram_cs=0, ram_we=0, ram_oe=0; ram_addr/ram_wdata hold their previous values.
REQ-026 A pending-read register records (read issued, id); on a read command in cycle t+1, rsp_valid=1 and rsp_id=g in cycle t+2.
REQ-027 Writes never produce rsp_valid.
REQ-028 Back-to-back: one transfer per cycle is sustained; reads in consecutive cycles produce consecutive rsp_valid pulses in grant order.
REQ-029 Read-after-write to same address granted in consecutive cycles returns the new data (RAM commit precedes read command by one cycle).
REQ-030 Deasserting arb_en blocks new grants only; commands and responses already in flight complete normally.
REQ-031 Only req_valid bits with index < N_REQ are considered; ptr never exceeds N_REQ-1.

Reset
REQ-032 While rst=1, immediately and independent of clk: ptr=0, ram_cs=0, ram_we=0, ram_oe=0, ram_addr=0, ram_wdata=0, rsp_valid=0, rsp_id=0, pending-read cleared.
REQ-033 rst asserted mid-operation discards in-flight commands and responses; no rsp_valid follows deassertion for them.
REQ-034 First cycle after rst deassertion arbitrates normally starting from requester 0.

Verification
REQ-035 All four requesters read continuously, arb_en=1 -> grants 0,1,2,3,0,... one per cycle; rsp_id sequence 0,1,2,3 two cycles behind grants.
REQ-036 Req 2 writes 0xDEADBEEF to addr 5, then req 1 reads addr 5 next cycle -> rsp_valid with rsp_id=1, rsp_rdata=0xDEADBEEF two cycles after the read grant.
REQ-037 Only req 3 valid, ptr=0 -> req_ready=4'b1000, ptr becomes 0 next cycle.
REQ-038 arb_en=0 with req_valid=4'b1111 -> req_ready=0, ram_cs=0 every cycle; a read granted the cycle before arb_en falls still returns rsp_valid.
REQ-039 rst pulsed in the cycle after a read grant -> ram_cs, rsp_valid drop immediately, no response appears, ptr=0 after release.
REQ-040 Requesters 0 and 2 valid, ptr=1 -> req 2 granted first, then req 0.
